pll_reset_sequencer: RTL



---
 rtl/pll_rst_pkg.sv | 19 +
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_reset_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_rst_pkg;

  localparam int unsigned RETRY_W                 = 8;
  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 8;
  localparam int unsigned DEF_CNT_W               = 17;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops resolve metastability on the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the system reset; re-pulses on timeout or loss of lock.
// Optional retry limit with a terminal FAIL state: define PLL_RETRY_LIMIT_EN.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost,
  output logic               fail
);

`ifdef PLL_RETRY_LIMIT_EN
  localparam bit RETRY_LIMIT_ON = 1'b1;
`else
  localparam bit RETRY_LIMIT_ON = 1'b0;
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               locked_s;
  logic [RETRY_W-1:0] retry_inc_c;
  state_t             retry_state_c;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Saturating retry increment and where a retry leads (FAIL once the limit is hit).
  always_comb begin
    retry_inc_c   = (retry_cnt == '1) ? retry_cnt : retry_cnt + RETRY_W'(1);
    retry_state_c = RESET_PLL;
    if (RETRY_LIMIT_ON && (retry_inc_c == RETRY_W'(MAX_RETRIES)))
      retry_state_c = FAIL;
  end

  // Sequencer FSM with Moore outputs registered alongside the state.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
      fail      <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (cnt == CNT_W'(RST_PULSE_CYCLES - 1)) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            state     <= retry_state_c;
            cnt       <= '0;
            retry_cnt <= retry_inc_c;
            pll_rst   <= (retry_state_c == RESET_PLL);
            fail      <= (retry_state_c == FAIL);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            state     <= RUN;
            sys_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state     <= retry_state_c;
            cnt       <= '0;
            lock_lost <= 1'b1;
            retry_cnt <= retry_inc_c;
            pll_rst   <= (retry_state_c == RESET_PLL);
            fail      <= (retry_state_c == FAIL);
            sys_rst_n <= 1'b0;
          end
        end
        FAIL: begin
          // Terminal until rst; lock is ignored.
          pll_rst   <= 1'b0;
          sys_rst_n <= 1'b0;
          fail      <= 1'b1;
        end
        default: begin
          state     <= RESET_PLL;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule
